trace_filter_ctrl: RTL and testbench

Control block for trace_filter. It owns the filter's send-after-event mask (branch, jump, wfi, trap, interrupt) and arms and disarms monitoring with a small state machine. Mask updates are applied only at instruction boundaries. The block also gates the filtered trace stream and keeps saturating forwarded and dropped counters. It sits between the configuration register bus and trace_filter, next to the core's pc_valid/instr trace port.

---
 rtl/trace_filter_ctrl.sv | 142 ++++++++++++++
 tb/tb_trace_filter_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_filter_ctrl.sv
// Control block for trace_filter: arms/disarms monitoring, applies send-after-event
// mask updates at instruction boundaries, gates the trace stream and counts traffic.
module trace_filter_ctrl #(
    parameter int              COUNTER_WIDTH  = 64,
    parameter int              ARM_DELAY      = 4,
    parameter int              UPDATE_TIMEOUT = 16,
    parameter logic [4:0]      RESET_MASK     = 5'b10000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     disarm,
    input  logic                     clear_counters,
    input  logic                     cfg_wr_en,
    input  logic [4:0]               cfg_wr_mask,
    output logic                     cfg_wr_ready,
    input  logic                     pc_valid,
    input  logic                     drop_instr,
    output logic [4:0]               filter_mask,
    output logic                     monitor_en,
    output logic                     trace_valid,
    output logic [1:0]               ctrl_state,
    output logic [COUNTER_WIDTH-1:0] forwarded_count,
    output logic [COUNTER_WIDTH-1:0] dropped_count,
    output logic [COUNTER_WIDTH-1:0] update_count
);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMING   = 2'd1,
        ACTIVE   = 2'd2,
        DRAINING = 2'd3
    } state_t;

    localparam int ARM_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam int TO_W  = $clog2(UPDATE_TIMEOUT + 1);
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_DELAY - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(UPDATE_TIMEOUT - 1);

    state_t             state;
    logic [ARM_W-1:0]   arm_timer;
    logic [TO_W-1:0]    timeout_timer;
    logic               pending;
    logic [4:0]         shadow_mask;
    logic               apply_now;

    assign monitor_en   = (state == ACTIVE) || (state == DRAINING);
    assign ctrl_state   = state;
    assign cfg_wr_ready = ~pending;

    // Outside monitoring any pending mask applies at once; while monitoring it waits for
    // an idle trace cycle, or is forced once it has waited UPDATE_TIMEOUT edges.
    always_comb begin
        apply_now = 1'b0;
        if (pending) begin
            apply_now = ~monitor_en | ~pc_valid | (timeout_timer == TO_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DISABLED;
            arm_timer <= '0;
        end else begin
            case (state)
                DISABLED: begin
                    if (arm && !disarm) begin
                        state     <= ARMING;
                        arm_timer <= ARM_LOAD;
                    end
                end
                ARMING: begin
                    if (disarm) begin
                        state     <= DISABLED;
                        arm_timer <= '0;
                    end else if (arm_timer == '0) begin
                        state <= ACTIVE;
                    end else begin
                        arm_timer <= arm_timer - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (disarm) begin
                        state <= pc_valid ? DRAINING : DISABLED;
                    end
                end
                DRAINING: begin
                    if (!pc_valid) begin
                        state <= DISABLED;
                    end
                end
                default: state <= DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter_mask   <= RESET_MASK;
            shadow_mask   <= RESET_MASK;
            pending       <= 1'b0;
            timeout_timer <= '0;
        end else if (apply_now) begin
            filter_mask   <= shadow_mask;
            pending       <= 1'b0;
            timeout_timer <= '0;
        end else if (pending) begin
            timeout_timer <= timeout_timer + 1'b1;
        end else if (cfg_wr_en) begin
            shadow_mask <= cfg_wr_mask;
            pending     <= 1'b1;
        end
    end

    // Counters saturate at all-ones; a clear beats any coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid     <= 1'b0;
            forwarded_count <= '0;
            dropped_count   <= '0;
            update_count    <= '0;
        end else begin
            trace_valid <= monitor_en & pc_valid & ~drop_instr;
            if (clear_counters) begin
                forwarded_count <= '0;
                dropped_count   <= '0;
                update_count    <= '0;
            end else begin
                if (monitor_en && pc_valid && !drop_instr && (forwarded_count != '1)) begin
                    forwarded_count <= forwarded_count + 1'b1;
                end
                if (monitor_en && pc_valid && drop_instr && (dropped_count != '1)) begin
                    dropped_count <= dropped_count + 1'b1;
                end
                if (apply_now && (update_count != '1)) begin
                    update_count <= update_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_filter_ctrl.sv
// Table-driven bench for trace_filter_ctrl with 4-bit counters so saturation is reachable.
module tb_trace_filter_ctrl;

    localparam int CW = 4;
    localparam logic [4:0] M0 = 5'b10000;
    localparam logic [4:0] M1 = 5'b00011;
    localparam logic [4:0] M2 = 5'b01100;

    logic          clk, rst;
    logic          arm, disarm, clear_counters, cfg_wr_en, pc_valid, drop_instr;
    logic [4:0]    cfg_wr_mask;
    logic          cfg_wr_ready, monitor_en, trace_valid;
    logic [4:0]    filter_mask;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] forwarded_count, dropped_count, update_count;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic          arm, disarm, clr, wr_en;
        logic [4:0]    wr_mask;
        logic          pv, drop;
        logic [1:0]    e_state;
        logic          e_tv;
        logic [4:0]    e_mask;
        logic          e_ready;
        logic [CW-1:0] e_fwd, e_drp, e_upd;
    } vec_t;

    vec_t vecs[23];

    trace_filter_ctrl #(
        .COUNTER_WIDTH(CW), .ARM_DELAY(4), .UPDATE_TIMEOUT(16), .RESET_MASK(M0)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
        .clear_counters(clear_counters), .cfg_wr_en(cfg_wr_en),
        .cfg_wr_mask(cfg_wr_mask), .cfg_wr_ready(cfg_wr_ready),
        .pc_valid(pc_valid), .drop_instr(drop_instr), .filter_mask(filter_mask),
        .monitor_en(monitor_en), .trace_valid(trace_valid), .ctrl_state(ctrl_state),
        .forwarded_count(forwarded_count), .dropped_count(dropped_count),
        .update_count(update_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic a, input logic d, input logic c, input logic we,
                                input logic [4:0] wm, input logic pv, input logic dr,
                                input logic [1:0] st, input logic tv, input logic [4:0] m,
                                input logic rdy, input int f, input int dp, input int u);
        vec_t v;
        v.arm = a; v.disarm = d; v.clr = c; v.wr_en = we; v.wr_mask = wm;
        v.pv = pv; v.drop = dr; v.e_state = st; v.e_tv = tv; v.e_mask = m;
        v.e_ready = rdy; v.e_fwd = CW'(f); v.e_drp = CW'(dp); v.e_upd = CW'(u);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        arm = v.arm; disarm = v.disarm; clear_counters = v.clr;
        cfg_wr_en = v.wr_en; cfg_wr_mask = v.wr_mask;
        pc_valid = v.pv; drop_instr = v.drop;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic e_mon;
        e_mon = (v.e_state == 2'd2) || (v.e_state == 2'd3);
        vectors_applied++;
        if (ctrl_state !== v.e_state) begin
            miscompares++;
            $display("[TB] FAIL %s ctrl_state got %0d want %0d", name, ctrl_state, v.e_state);
        end
        if (monitor_en !== e_mon) begin
            miscompares++;
            $display("[TB] FAIL %s monitor_en got %0b want %0b", name, monitor_en, e_mon);
        end
        if (trace_valid !== v.e_tv) begin
            miscompares++;
            $display("[TB] FAIL %s trace_valid got %0b want %0b", name, trace_valid, v.e_tv);
        end
        if (filter_mask !== v.e_mask) begin
            miscompares++;
            $display("[TB] FAIL %s filter_mask got %b want %b", name, filter_mask, v.e_mask);
        end
        if (cfg_wr_ready !== v.e_ready) begin
            miscompares++;
            $display("[TB] FAIL %s cfg_wr_ready got %0b want %0b", name, cfg_wr_ready, v.e_ready);
        end
        if (forwarded_count !== v.e_fwd) begin
            miscompares++;
            $display("[TB] FAIL %s forwarded_count got %0d want %0d", name, forwarded_count, v.e_fwd);
        end
        if (dropped_count !== v.e_drp) begin
            miscompares++;
            $display("[TB] FAIL %s dropped_count got %0d want %0d", name, dropped_count, v.e_drp);
        end
        if (update_count !== v.e_upd) begin
            miscompares++;
            $display("[TB] FAIL %s update_count got %0d want %0d", name, update_count, v.e_upd);
        end
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        checkOutput(v, name);
    endtask

    initial begin
        // arm, disarm, clr, wr_en, wr_mask, pv, drop | state, tv, mask, ready, fwd, drp, upd
        vecs[0]  = mk(1,0,0,0,0,  0,0, 1,0,M0,1, 0,0,0);
        vecs[1]  = mk(0,0,0,0,0,  0,0, 1,0,M0,1, 0,0,0);
        vecs[2]  = mk(0,0,0,0,0,  0,0, 1,0,M0,1, 0,0,0);
        vecs[3]  = mk(1,0,0,0,0,  0,0, 1,0,M0,1, 0,0,0);
        vecs[4]  = mk(0,0,0,0,0,  0,0, 2,0,M0,1, 0,0,0);
        vecs[5]  = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 1,0,0);
        vecs[6]  = mk(0,0,0,0,0,  1,1, 2,0,M0,1, 1,1,0);
        vecs[7]  = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 2,1,0);
        vecs[8]  = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 3,1,0);
        vecs[9]  = mk(0,0,0,0,0,  1,1, 2,0,M0,1, 3,2,0);
        vecs[10] = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 4,2,0);
        vecs[11] = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 5,2,0);
        vecs[12] = mk(0,0,0,0,0,  1,1, 2,0,M0,1, 5,3,0);
        vecs[13] = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 6,3,0);
        vecs[14] = mk(0,0,0,0,0,  1,0, 2,1,M0,1, 7,3,0);
        vecs[15] = mk(0,0,0,0,0,  0,0, 2,0,M0,1, 7,3,0);
        vecs[16] = mk(0,0,1,0,0,  0,0, 2,0,M0,1, 0,0,0);
        vecs[17] = mk(0,0,0,1,M1, 1,0, 2,1,M0,0, 1,0,0);
        vecs[18] = mk(0,0,0,0,0,  1,0, 2,1,M0,0, 2,0,0);
        vecs[19] = mk(0,0,0,0,0,  1,0, 2,1,M0,0, 3,0,0);
        vecs[20] = mk(0,0,0,0,0,  1,0, 2,1,M0,0, 4,0,0);
        vecs[21] = mk(0,0,0,0,0,  0,0, 2,0,M1,1, 4,0,1);
        vecs[22] = mk(0,0,0,1,M2, 1,1, 2,0,M1,0, 4,1,1);

        rst = 1'b1;
        arm = 0; disarm = 0; clear_counters = 0; cfg_wr_en = 0; cfg_wr_mask = '0;
        pc_valid = 0; drop_instr = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput(mk(0,0,0,0,0,0,0, 0,0,M0,1, 0,0,0), "reset");

        for (int i = 0; i < 23; i++) begin
            runVec(vecs[i], $sformatf("row%0d", i));
        end

        // Forced apply: write accepted at row22, no idle cycle, lands exactly 16 edges later
        for (int k = 1; k <= 16; k++) begin
            runVec(mk(0,0,0,0,0, 1,1, 2,0, (k < 16) ? M1 : M2, (k == 16),
                      4, (1 + k > 15) ? 15 : 1 + k, (k == 16) ? 2 : 1),
                   $sformatf("timeout%0d", k));
        end

        // Disarm while instructions still flow: drain, then freeze
        runVec(mk(0,0,1,0,0, 0,0, 2,0,M2,1, 0,0,0), "clr_pre_drain");
        runVec(mk(0,1,0,0,0, 1,0, 3,1,M2,1, 1,0,0), "disarm_busy");
        runVec(mk(0,0,0,0,0, 1,0, 3,1,M2,1, 2,0,0), "drain1");
        runVec(mk(0,0,0,0,0, 1,0, 3,1,M2,1, 3,0,0), "drain2");
        runVec(mk(0,0,0,0,0, 0,0, 0,0,M2,1, 3,0,0), "drain_exit");
        runVec(mk(0,0,0,0,0, 1,0, 0,0,M2,1, 3,0,0), "frozen_fwd");
        runVec(mk(0,0,0,0,0, 1,1, 0,0,M2,1, 3,0,0), "frozen_drop");

        runVec(mk(1,1,0,0,0, 0,0, 0,0,M2,1, 3,0,0), "arm_disarm");
        runVec(mk(0,0,0,0,0, 0,0, 0,0,M2,1, 3,0,0), "arm_disarm_idle");

        // Mask writes while disabled apply one edge later; writes while pending are dropped
        runVec(mk(0,0,0,1,M1,    0,0, 0,0,M2,0, 3,0,0), "wr_dis");
        runVec(mk(0,0,0,1,5'h1F, 0,0, 0,0,M1,1, 3,0,1), "wr_dis_apply");
        runVec(mk(0,0,0,0,0,     0,0, 0,0,M1,1, 3,0,1), "wr_ignored");
        runVec(mk(0,0,0,1,M1,    0,0, 0,0,M1,0, 3,0,1), "wr_same");
        runVec(mk(0,0,0,0,0,     0,0, 0,0,M1,1, 3,0,2), "wr_same_apply");

        runVec(mk(1,0,0,0,0, 0,0, 1,0,M1,1, 3,0,2), "arm2");
        runVec(mk(0,1,0,0,0, 0,0, 0,0,M1,1, 3,0,2), "arming_disarm");
        runVec(mk(0,0,0,0,0, 0,0, 0,0,M1,1, 3,0,2), "arming_disarm_idle");

        runVec(mk(1,0,0,0,0, 0,0, 1,0,M1,1, 3,0,2), "arm3");
        for (int k = 1; k <= 3; k++) begin
            runVec(mk(0,0,0,0,0, 0,0, 1,0,M1,1, 3,0,2), $sformatf("arm3_wait%0d", k));
        end
        runVec(mk(0,0,0,0,0, 0,0, 2,0,M1,1, 3,0,2), "arm3_active");
        runVec(mk(0,1,0,0,0, 0,0, 0,0,M1,1, 3,0,2), "disarm_idle_direct");

        runVec(mk(1,0,0,0,0, 0,0, 1,0,M1,1, 3,0,2), "arm4");
        for (int k = 1; k <= 3; k++) begin
            runVec(mk(0,0,0,0,0, 0,0, 1,0,M1,1, 3,0,2), $sformatf("arm4_wait%0d", k));
        end
        runVec(mk(0,0,0,0,0, 0,0, 2,0,M1,1, 3,0,2), "arm4_active");
        runVec(mk(0,0,0,0,0, 1,0, 2,1,M1,1, 4,0,2), "fwd_before_clr");
        runVec(mk(0,0,1,0,0, 1,0, 2,1,M1,1, 0,0,0), "clr_with_fwd");

        for (int k = 1; k <= 17; k++) begin
            runVec(mk(0,0,0,0,0, 1,0, 2,1,M1,1, (k > 15) ? 15 : k, 0, 0),
                   $sformatf("sat%0d", k));
        end

        // Reset lands mid-cycle with an update still pending
        runVec(mk(0,0,0,1,M2, 1,0, 2,1,M1,0, 15,0,0), "wr_before_reset");
        arm = 0; disarm = 0; clear_counters = 0; cfg_wr_en = 0; pc_valid = 1; drop_instr = 0;
        #3;
        rst = 1'b1;
        #1;
        checkOutput(mk(0,0,0,0,0, 0,0, 0,0,M0,1, 0,0,0), "async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        runVec(mk(0,0,0,0,0, 0,0, 0,0,M0,1, 0,0,0), "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
